pid_controller_core: RTL and testbench
======================================

Name:
pid_controller_core

Overview:
- Single-channel PID compute block with an output post-processor (OPP).
- Takes signed ADC samples with a data-valid strobe and computes u = P·e + I·Σe + D·Δe, where e = setpoint − sample.
- Presents u on a debug output, then offsets it by an initial value and clamps it to a 16-bit unsigned DAC code.
- Sits between the oversample filter/router and the DAC driver in the pid_controller datapath.

Parameters:
- W_DATA, 18, sample width and PID output width (signed).
- W_COEF, 16, setpoint and coefficient width (signed).
- W_OPP, 16, OPP output width (unsigned).
- W_INTG, 32, integral accumulator width (signed, saturating).

Ports:
- clk_in, input, 1, system clock; all logic on the rising edge.
- rst_n_in, input, 1, asynchronous active-low reset.
- data_in, input, W_DATA, signed sample.
- data_dv_in, input, 1, one-cycle sample strobe.
- lock_en_in, input, 1, enables PID locking.
- update_in, input, 1, one-cycle parameter load pulse.
- update_en_in, input, 1, qualifies update_in for this channel.
- setpoint_in, input, W_COEF, signed setpoint.
- p_coef_in, input, W_COEF, signed P coefficient.
- i_coef_in, input, W_COEF, signed I coefficient.
- d_coef_in, input, W_COEF, signed D coefficient.
- opp_init_in, input, W_OPP, output offset.
- opp_min_in, input, W_OPP, clamp minimum.
- opp_max_in, input, W_OPP, clamp maximum.
- pid_data_out, output, W_DATA, signed PID result.
- pid_dv_out, output, 1, PID result strobe.
- opp_data_out, output, W_OPP, clamped output code.
- opp_dv_out, output, 1, output code strobe.

Behaviour:
- Reset (async, rst_n_in=0):
  - All parameter registers, integral and error_prev clear to 0.
  - pid_data_out=0, pid_dv_out=0, opp_data_out=0, opp_dv_out=0.
  - Pipeline valid bits clear.
- Parameter load:
  - When update_in=1 and update_en_in=1 on an edge, latch setpoint, P/I/D, init, min and max.
  - New values apply to samples strobed on later cycles. Integral is not cleared.
  - update_in with update_en_in=0 is ignored.
- Lock disabled (lock_en_in=0):
  - data_dv_in is ignored.
  - integral and error_prev are held at 0.
  - No pid_dv_out or opp_dv_out pulses.
  - opp_data_out tracks the latched init value.
- Pipeline, lock enabled, data_dv_in at cycle T:
  - T+1: e = setpoint − data_in, sign-extended to W_DATA+1.
  - T+2: integral ← sat_W_INTG(integral + e); derivative = e − error_prev; error_prev ← e.
  - T+3: products P·e, I·integral, D·derivative at full precision.
  - T+4: sum, saturate to signed W_DATA; drive pid_data_out; pid_dv_out=1 for exactly one cycle.
  - T+5: s = init + pid_data_out (signed, wide); clamp to max first, then to min. If min>max, min wins. Negative s yields min.
  - T+5: drive opp_data_out; opp_dv_out=1 for exactly one cycle.
- Strobe spacing and timing:
  - Back-to-back data_dv_in strobes (every cycle) are supported fully pipelined.
  - Outputs hold their value between strobes.
- lock_en_in falling mid-pipeline:
  - Samples already accepted complete and emit strobes.
  - State clears on the cycle after the last in-flight sample leaves stage T+2.
- Saturation:
  - The integral never wraps.
  - pid_data_out saturates to [−2^(W_DATA−1), 2^(W_DATA−1)−1].
- Exactness: with no saturation, pid_data_out equals exactly P·e + I·Σe + D·(e − e_prev). The first sample after lock enable uses e_prev=0.

Test Plan:
- Reset values: reset, then release → all outputs 0. A data_dv_in pulse with lock_en_in=0 → no strobes; opp_data_out = latched init.
- Basic PID: load sp=0, P=10, I=3, D=2, init=500, min=99, max=1111; lock on.
  - Sample 10 → pid_data_out=−150 at T+4, opp_data_out=350 at T+5.
  - Next sample −5 → pid_data_out=65, opp_data_out=565.
- Clamp low: fresh lock, sample 1000 → pid=−15000, opp=99. Clamp high: fresh lock, sample −1000 → pid=15000, opp=1111.
- Update gating: update_in with update_en_in=0 and P=99 → next result still uses P=10. With update_en_in=1 → P=99 applies to the following sample only; integral retained.
- Lock cycle: after several samples, drop lock_en_in, re-raise, sample 10 → pid=−150 again (integral and e_prev cleared).
- Throughput and saturation:
  - 8 consecutive-cycle strobes → 8 consecutive pid_dv_out pulses with correct values.
  - Sample −131072 with P=32767 → pid_data_out=131071 (saturated).

Source files
------------

// File: rtl/pid_controller_core.sv
// Single-channel PID compute pipeline (error, integral/derivative, products, sum)
// followed by an offset-and-clamp stage producing an unsigned DAC code.
module pid_controller_core #(
  parameter int W_DATA = 18,
  parameter int W_COEF = 16,
  parameter int W_OPP  = 16,
  parameter int W_INTG = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic signed [W_DATA-1:0] data_in,
  input  logic                     data_dv_in,
  input  logic                     lock_en_in,
  input  logic                     update_in,
  input  logic                     update_en_in,
  input  logic signed [W_COEF-1:0] setpoint_in,
  input  logic signed [W_COEF-1:0] p_coef_in,
  input  logic signed [W_COEF-1:0] i_coef_in,
  input  logic signed [W_COEF-1:0] d_coef_in,
  input  logic        [W_OPP-1:0]  opp_init_in,
  input  logic        [W_OPP-1:0]  opp_min_in,
  input  logic        [W_OPP-1:0]  opp_max_in,
  output logic signed [W_DATA-1:0] pid_data_out,
  output logic                     pid_dv_out,
  output logic        [W_OPP-1:0]  opp_data_out,
  output logic                     opp_dv_out
);

  localparam int W_ERR  = W_DATA + 1;
  localparam int W_DER  = W_DATA + 2;
  localparam int W_IS   = W_INTG + 1;
  localparam int W_PP   = W_COEF + W_ERR;
  localparam int W_IP   = W_COEF + W_INTG;
  localparam int W_DP   = W_COEF + W_DER;
  localparam int W_PMAX = (W_IP > W_DP) ? ((W_IP > W_PP) ? W_IP : W_PP)
                                        : ((W_DP > W_PP) ? W_DP : W_PP);
  localparam int W_SUM  = W_PMAX + 2;
  localparam int W_S    = ((W_OPP + 1 > W_DATA) ? W_OPP + 1 : W_DATA) + 1;
  localparam logic [W_INTG-1:0] INTG_MIN = {1'b1, {(W_INTG-1){1'b0}}};
  localparam logic [W_INTG-1:0] INTG_MAX = {1'b0, {(W_INTG-1){1'b1}}};
  localparam logic [W_DATA-1:0] PID_MIN  = {1'b1, {(W_DATA-1){1'b0}}};
  localparam logic [W_DATA-1:0] PID_MAX  = {1'b0, {(W_DATA-1){1'b1}}};

  // Interface is strobe-only: a sample is taken on any edge where data_dv_in
  // and lock_en_in are both high; results appear as one-cycle strobes, no backpressure.
  logic signed [W_COEF-1:0] sp_q, p_q, i_q, d_q;
  logic        [W_OPP-1:0]  init_q, min_q, max_q;
  logic                     accept;
  logic                     v1_q, v2_q, v3_q;
  logic signed [W_ERR-1:0]  e1_d, e1_q, eprev_q;
  logic signed [W_IS-1:0]   intg_sum;
  logic signed [W_INTG-1:0] intg_d, intg_q;
  logic signed [W_DER-1:0]  der_d, der_q;
  logic signed [W_PP-1:0]   pp_q;
  logic signed [W_IP-1:0]   ip_q;
  logic signed [W_DP-1:0]   dp_q;
  logic signed [W_SUM-1:0]  sum_d;
  logic                     sum_fits;
  logic signed [W_DATA-1:0] pid_d, pid_q;
  logic                     pid_dv_q;
  logic signed [W_S-1:0]    s_d, max_s, min_s;
  logic                     gt_max, lt_min;
  logic        [W_OPP-1:0]  opp_d, opp_q;
  logic                     opp_dv_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sp_q   <= '0;
      p_q    <= '0;
      i_q    <= '0;
      d_q    <= '0;
      init_q <= '0;
      min_q  <= '0;
      max_q  <= '0;
    end else if (update_in && update_en_in) begin
      sp_q   <= setpoint_in;
      p_q    <= p_coef_in;
      i_q    <= i_coef_in;
      d_q    <= d_coef_in;
      init_q <= opp_init_in;
      min_q  <= opp_min_in;
      max_q  <= opp_max_in;
    end
  end

  assign accept   = data_dv_in & lock_en_in;
  assign e1_d     = W_ERR'(sp_q) - W_ERR'(data_in);
  assign intg_sum = W_IS'(intg_q) + W_IS'(e1_q);
  assign intg_d   = (intg_sum[W_INTG] == intg_sum[W_INTG-1]) ? intg_sum[W_INTG-1:0]
                  : (intg_sum[W_INTG] ? INTG_MIN : INTG_MAX);
  assign der_d    = W_DER'(e1_q) - W_DER'(eprev_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q    <= 1'b0;
      e1_q    <= '0;
      v2_q    <= 1'b0;
      intg_q  <= '0;
      eprev_q <= '0;
      der_q   <= '0;
    end else begin
      v1_q <= accept;
      if (accept) e1_q <= e1_d;
      v2_q <= v1_q;
      // In-flight samples finish before the lock-off clear takes effect.
      if (v1_q) begin
        intg_q  <= intg_d;
        der_q   <= der_d;
        eprev_q <= e1_q;
      end else if (!lock_en_in) begin
        intg_q  <= '0;
        eprev_q <= '0;
      end
    end
  end

  assign sum_d    = W_SUM'(pp_q) + W_SUM'(ip_q) + W_SUM'(dp_q);
  assign sum_fits = (&sum_d[W_SUM-1:W_DATA-1]) | ~(|sum_d[W_SUM-1:W_DATA-1]);
  assign pid_d    = sum_fits ? sum_d[W_DATA-1:0] : (sum_d[W_SUM-1] ? PID_MIN : PID_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v3_q     <= 1'b0;
      pp_q     <= '0;
      ip_q     <= '0;
      dp_q     <= '0;
      pid_q    <= '0;
      pid_dv_q <= 1'b0;
    end else begin
      v3_q <= v2_q;
      // eprev_q already holds the error of the sample in this stage.
      if (v2_q) begin
        pp_q <= W_PP'(p_q) * W_PP'(eprev_q);
        ip_q <= W_IP'(i_q) * W_IP'(intg_q);
        dp_q <= W_DP'(d_q) * W_DP'(der_q);
      end
      pid_dv_q <= v3_q;
      if (v3_q) pid_q <= pid_d;
    end
  end

  assign s_d    = W_S'($signed({1'b0, init_q})) + W_S'(pid_q);
  assign max_s  = W_S'($signed({1'b0, max_q}));
  assign min_s  = W_S'($signed({1'b0, min_q}));
  assign gt_max = s_d > max_s;
  // Clamp to max first, then min, so min wins when the limits cross.
  assign lt_min = gt_max ? (max_q < min_q) : (s_d < min_s);
  assign opp_d  = lt_min ? min_q : (gt_max ? max_q : s_d[W_OPP-1:0]);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      opp_q    <= '0;
      opp_dv_q <= 1'b0;
    end else begin
      opp_dv_q <= pid_dv_q;
      if (pid_dv_q) opp_q <= opp_d;
      else if (!lock_en_in) opp_q <= init_q;
    end
  end

  assign pid_data_out = pid_q;
  assign pid_dv_out   = pid_dv_q;
  assign opp_data_out = opp_q;
  assign opp_dv_out   = opp_dv_q;

endmodule

// File: tb/tb_pid_controller_core.sv
// Bench for pid_controller_core: directed literal cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_pid_controller_core;

  localparam int W_DATA = 18;
  localparam int W_COEF = 16;
  localparam int W_OPP  = 16;
  localparam int W_INTG = 32;
  localparam longint INTG_HI = (longint'(1) << (W_INTG - 1)) - 1;
  localparam longint INTG_LO = -INTG_HI - 1;
  localparam longint PID_HI  = (longint'(1) << (W_DATA - 1)) - 1;
  localparam longint PID_LO  = -PID_HI - 1;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [W_DATA-1:0] data_in = '0;
  logic data_dv_in = 1'b0;
  logic lock_en_in = 1'b0;
  logic update_in = 1'b0;
  logic update_en_in = 1'b0;
  logic [W_COEF-1:0] setpoint_in = '0;
  logic [W_COEF-1:0] p_coef_in = '0;
  logic [W_COEF-1:0] i_coef_in = '0;
  logic [W_COEF-1:0] d_coef_in = '0;
  logic [W_OPP-1:0] opp_init_in = '0;
  logic [W_OPP-1:0] opp_min_in = '0;
  logic [W_OPP-1:0] opp_max_in = '0;
  logic [W_DATA-1:0] pid_data_out;
  logic pid_dv_out;
  logic [W_OPP-1:0] opp_data_out;
  logic opp_dv_out;

  pid_controller_core #(
    .W_DATA(W_DATA), .W_COEF(W_COEF), .W_OPP(W_OPP), .W_INTG(W_INTG)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .data_in(data_in), .data_dv_in(data_dv_in),
    .lock_en_in(lock_en_in), .update_in(update_in), .update_en_in(update_en_in),
    .setpoint_in(setpoint_in), .p_coef_in(p_coef_in), .i_coef_in(i_coef_in),
    .d_coef_in(d_coef_in), .opp_init_in(opp_init_in), .opp_min_in(opp_min_in),
    .opp_max_in(opp_max_in), .pid_data_out(pid_data_out), .pid_dv_out(pid_dv_out),
    .opp_data_out(opp_data_out), .opp_dv_out(opp_dv_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // reference model state
  longint m_sp = 0, m_p = 0, m_i = 0, m_d = 0;
  longint m_init = 0, m_min = 0, m_max = 0;
  longint m_intg = 0, m_eprev = 0;

  // scoreboard
  logic [W_DATA-1:0] exp_pid_q[$];
  logic [W_OPP-1:0]  exp_opp_q[$];
  int pid_due_q[$];
  int opp_due_q[$];
  logic [W_DATA-1:0] last_pid = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint clip(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int rs(input int lim);
    return int'($urandom_range(0, 2 * lim)) - lim;
  endfunction

  task automatic model_push(input longint x);
    longint e, d, u, s;
    e = m_sp - x;
    m_intg = clip(m_intg + e, INTG_LO, INTG_HI);
    d = e - m_eprev;
    m_eprev = e;
    u = clip(m_p * e + m_i * m_intg + m_d * d, PID_LO, PID_HI);
    s = m_init + u;
    if (s > m_max) s = m_max;
    if (s < m_min) s = m_min;
    exp_pid_q.push_back(W_DATA'(u));
    pid_due_q.push_back(cyc + 4);
    exp_opp_q.push_back(W_OPP'(s));
    opp_due_q.push_back(cyc + 5);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int x);
    data_in = W_DATA'(x);
    data_dv_in = 1'b1;
    if (lock_en_in) model_push(longint'(x));
    step();
    data_dv_in = 1'b0;
    data_in = W_DATA'($urandom);
  endtask

  task automatic do_update(input bit en, input int sp, input int p, input int i, input int d,
                           input int init, input int mn, input int mx);
    setpoint_in = W_COEF'(sp);
    p_coef_in = W_COEF'(p);
    i_coef_in = W_COEF'(i);
    d_coef_in = W_COEF'(d);
    opp_init_in = W_OPP'(init);
    opp_min_in = W_OPP'(mn);
    opp_max_in = W_OPP'(mx);
    update_in = 1'b1;
    update_en_in = en;
    step();
    update_in = 1'b0;
    update_en_in = 1'($urandom);
    setpoint_in = W_COEF'($urandom);
    p_coef_in = W_COEF'($urandom);
    i_coef_in = W_COEF'($urandom);
    d_coef_in = W_COEF'($urandom);
    opp_init_in = W_OPP'($urandom);
    opp_min_in = W_OPP'($urandom);
    opp_max_in = W_OPP'($urandom);
    if (en) begin
      m_sp = sp; m_p = p; m_i = i; m_d = d;
      m_init = init; m_min = mn; m_max = mx;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_pid_q.size() != 0 || exp_opp_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    if (exp_pid_q.size() != 0 || exp_opp_q.size() != 0) begin
      check("drain_timeout", exp_pid_q.size() + exp_opp_q.size(), 0);
      exp_pid_q.delete(); pid_due_q.delete();
      exp_opp_q.delete(); opp_due_q.delete();
    end
    step();
  endtask

  task automatic set_lock(input bit v);
    lock_en_in = v;
    step();
    if (!v) begin
      m_intg = 0;
      m_eprev = 0;
      wait_idle();
      repeat (3) step();
      check("opp_tracks_init", longint'(opp_data_out), m_init);
    end
  endtask

  task automatic check_out(input string name, input longint pid, input longint opp);
    check({name, "_pid"}, longint'($signed(pid_data_out)), pid);
    check({name, "_opp"}, longint'(opp_data_out), opp);
  endtask

  task automatic rand_update();
    bit en;
    int sp, p, i, d, mn;
    en = ($urandom_range(0, 3) != 0);
    sp = ($urandom_range(0, 3) == 0) ? rs(32767) : rs(2000);
    p = ($urandom_range(0, 4) == 0) ? rs(32767) : rs(64);
    i = ($urandom_range(0, 4) == 0) ? rs(32767) : rs(16);
    d = ($urandom_range(0, 4) == 0) ? rs(32767) : rs(64);
    mn = int'($urandom_range(0, 30000));
    do_update(en, sp, p, i, d, int'($urandom_range(0, 65535)), mn,
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535))
                                          : int'($urandom_range(mn, 65535)));
  endtask

  // compare process: every cycle outside reset
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (pid_dv_out) begin
        if (exp_pid_q.size() == 0) begin
          check("pid_unexpected_strobe", 1, 0);
        end else begin
          logic [W_DATA-1:0] ep;
          int due;
          ep = exp_pid_q.pop_front();
          due = pid_due_q.pop_front();
          check("pid_value", longint'($signed(pid_data_out)), longint'($signed(ep)));
          check("pid_latency", cyc, due);
          last_pid = ep;
        end
      end else begin
        check("pid_hold", longint'($signed(pid_data_out)), longint'($signed(last_pid)));
      end
      if (opp_dv_out) begin
        if (exp_opp_q.size() == 0) begin
          check("opp_unexpected_strobe", 1, 0);
        end else begin
          logic [W_OPP-1:0] eo;
          int due;
          eo = exp_opp_q.pop_front();
          due = opp_due_q.pop_front();
          check("opp_value", longint'(opp_data_out), longint'(eo));
          check("opp_latency", cyc, due);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) step();
    check_out("in_reset", 0, 0);
    check("in_reset_pid_dv", longint'(pid_dv_out), 0);
    check("in_reset_opp_dv", longint'(opp_dv_out), 0);
    rst_n_in = 1'b1;
    step();
    check_out("after_reset", 0, 0);

    // lock off: strobe ignored, opp follows latched init
    send(10);
    do_update(1'b1, 0, 10, 3, 2, 500, 99, 1111);
    repeat (6) step();
    check("lock_off_init", longint'(opp_data_out), 500);

    set_lock(1'b1);
    send(10);
    wait_idle();
    check_out("basic1", -150, 350);
    send(-5);
    wait_idle();
    check_out("basic2", 65, 565);

    do_update(1'b0, 0, 99, 3, 2, 500, 99, 1111);
    send(-1);
    wait_idle();
    check_out("gated_update", -10, 490);
    do_update(1'b1, 0, 99, 3, 2, 500, 99, 1111);
    send(-1);
    wait_idle();
    check_out("enabled_update", 90, 590);

    set_lock(1'b0);
    do_update(1'b1, 0, 10, 3, 2, 500, 99, 1111);
    set_lock(1'b1);
    send(10);
    wait_idle();
    check_out("relock", -150, 350);

    set_lock(1'b0); set_lock(1'b1);
    send(1000);
    wait_idle();
    check_out("clamp_low", -15000, 99);
    set_lock(1'b0); set_lock(1'b1);
    send(-1000);
    wait_idle();
    check_out("clamp_high", 15000, 1111);

    set_lock(1'b0); set_lock(1'b1);
    for (int k = 0; k < 8; k++) send(rs(3000));
    wait_idle();

    for (int k = 0; k < 3; k++) send(rs(3000));
    set_lock(1'b0);

    do_update(1'b1, 0, 32767, 3, 2, 500, 99, 1111);
    set_lock(1'b1);
    send(-131072);
    wait_idle();
    check_out("pid_saturate", 131071, 1111);

    set_lock(1'b0);
    do_update(1'b1, 0, 10, 3, 2, 500, 2000, 1000);
    set_lock(1'b1);
    send(10);
    wait_idle();
    check_out("min_wins", -150, 2000);

    for (int r = 0; r < 40; r++) begin
      int mode;
      int n;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        set_lock(1'b0);
        rand_update();
        if ($urandom_range(0, 2) == 0) send(rs(131071));
        set_lock(1'b1);
      end else if (mode == 1) begin
        rand_update();
      end
      n = int'($urandom_range(1, 10));
      for (int k = 0; k < n; k++) begin
        send(($urandom_range(0, 5) == 0) ? rs(131071) : rs(3000));
        repeat ($urandom_range(0, 2)) step();
      end
      if ($urandom_range(0, 3) == 0) set_lock(1'b0);
      wait_idle();
      if (!lock_en_in) set_lock(1'b1);
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
